// File: rtl/draw_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : draw_pkg
// Purpose  : Shared types and defaults for the rectangle draw arbiter.
//            Coordinate and colour fields are stored at a fixed maximum width.
//            Users slice them down to the configured CW / COLW.
// Revision : 1.0 - initial release
// ============================================================================
package draw_pkg;

  localparam int DEF_NREQ = 4;
  localparam int DEF_CW   = 11;
  localparam int DEF_COLW = 1;

  // Storage widths; the configured CW/COLW must not exceed these.
  localparam int MAX_CW   = 16;
  localparam int MAX_COLW = 8;

  typedef logic [MAX_CW-1:0]   coord_t;
  typedef logic [MAX_COLW-1:0] color_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SCAN = 2'd2,
    DONE = 2'd3
  } state_t;

  typedef struct packed {
    coord_t llx;
    coord_t lly;
    coord_t trx;
    coord_t try;
    color_t color;
  } rect_t;

  // A rectangle whose top-right lies below/left of its lower-left draws nothing.
  // Fields are zero-extended, so the full-width compare matches a CW-bit compare.
  function automatic logic degenerate(input rect_t r);
    return (r.trx < r.llx) || (r.try < r.lly);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rect_scanner.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : rect_scanner
// Purpose  : Column-major x/y walker over a latched rectangle.
//            y runs lly..try, then x steps and y reloads.
//            Termination is by equality, so edge-of-range coordinates never overflow.
// Revision : 1.0 - initial release
// ============================================================================
module rect_scanner
  import draw_pkg::*;
#(
  parameter int CW = DEF_CW
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          start_i,
  input  logic          advance_i,
  input  rect_t         rect_i,
  output logic [CW-1:0] x_o,
  output logic [CW-1:0] y_o,
  output logic          last_o
);

  localparam logic [CW-1:0] COORD_ONE = {{(CW-1){1'b0}}, 1'b1};

  logic [CW-1:0] x_q;
  logic [CW-1:0] y_q;
  logic [CW-1:0] w_llx;
  logic [CW-1:0] w_lly;
  logic [CW-1:0] w_trx;
  logic [CW-1:0] w_try;
  logic          w_unused_rect;

  assign w_llx = rect_i.llx[CW-1:0];
  assign w_lly = rect_i.lly[CW-1:0];
  assign w_trx = rect_i.trx[CW-1:0];
  assign w_try = rect_i.try[CW-1:0];

  // Bits above CW and the colour are carried in the struct but not needed here.
  assign w_unused_rect = ^rect_i;

  // Load the start corner, then step y within the column and x between columns.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      x_q <= '0;
      y_q <= '0;
    end else if (start_i) begin
      x_q <= w_llx;
      y_q <= w_lly;
    end else if (advance_i) begin
      if (y_q == w_try) begin
        y_q <= w_lly;
        x_q <= x_q + COORD_ONE;
      end else begin
        y_q <= y_q + COORD_ONE;
      end
    end
  end

  assign x_o    = x_q;
  assign y_o    = y_q;
  assign last_o = (x_q == w_trx) && (y_q == w_try);

endmodule
`default_nettype wire

// File: rtl/rect_draw_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : rect_draw_arbiter
// Purpose  : Round-robin share of one rectangle-fill pixel engine between
//            NREQ clients. It emits one frame-buffer write per cycle.
//            It pulses a per-client done at job end.
// Options  : RECT_DRAW_STALL_EN - adds pix_ready back-pressure on pixel writes.
// Revision : 1.0 - initial release
// ============================================================================
module rect_draw_arbiter
  import draw_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int CW   = DEF_CW,
  parameter int COLW = DEF_COLW
) (
  input  logic                 clkf,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*CW-1:0]   llx,
  input  logic [NREQ*CW-1:0]   lly,
  input  logic [NREQ*CW-1:0]   trx,
  input  logic [NREQ*CW-1:0]   try,
  input  logic [NREQ*COLW-1:0] color,
`ifdef RECT_DRAW_STALL_EN
  input  logic                 pix_ready,
`endif
  output logic [NREQ-1:0]      grant,
  output logic [NREQ-1:0]      done,
  output logic                 busy,
  output logic [CW-1:0]        pix_x,
  output logic [CW-1:0]        pix_y,
  output logic [COLW-1:0]      pix_color,
  output logic                 pix_we
);

  localparam int IW = $clog2(NREQ);
  localparam logic [NREQ-1:0] ONEHOT0 = {{(NREQ-1){1'b0}}, 1'b1};

  state_t          state_q;
  logic [IW-1:0]   ptr_q;
  logic [IW-1:0]   idx_q;
  rect_t           job_q;
  logic [NREQ-1:0] grant_q;
  logic [NREQ-1:0] done_q;
  logic            busy_q;
  logic            we_q;

  logic            pick_valid_d;
  logic [IW-1:0]   pick_idx_d;
  rect_t           pick_rect_d;
  logic [IW-1:0]   ptr_d;
  logic            w_ready;
  logic            w_start;
  logic            w_advance;
  logic            w_last;
  logic            w_unused_color;

`ifdef RECT_DRAW_STALL_EN
  assign w_ready = pix_ready;
`else
  assign w_ready = 1'b1;
`endif

  // First requesting client at or after the pointer, wrapping modulo NREQ.
  always_comb begin
    int j;
    pick_valid_d = 1'b0;
    pick_idx_d   = '0;
    j            = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(ptr_q) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!pick_valid_d && req[j]) begin
        pick_valid_d = 1'b1;
        pick_idx_d   = IW'(j);
      end
    end
  end

  // Slice the chosen client's rectangle out of the packed input buses.
  always_comb begin
    pick_rect_d       = '0;
    pick_rect_d.llx   = coord_t'(llx[int'(pick_idx_d)*CW +: CW]);
    pick_rect_d.lly   = coord_t'(lly[int'(pick_idx_d)*CW +: CW]);
    pick_rect_d.trx   = coord_t'(trx[int'(pick_idx_d)*CW +: CW]);
    pick_rect_d.try   = coord_t'(try[int'(pick_idx_d)*CW +: CW]);
    pick_rect_d.color = color_t'(color[int'(pick_idx_d)*COLW +: COLW]);
  end

  assign ptr_d = (idx_q == IW'(NREQ - 1)) ? '0 : idx_q + IW'(1);

  // The scanner loads on the LOAD->SCAN edge.
  // It steps only on accepted, non-final pixels, so the outputs hold the last pixel.
  assign w_start   = (state_q == LOAD) && !degenerate(job_q);
  assign w_advance = (state_q == SCAN) && w_ready && !w_last;

  rect_scanner #(
    .CW(CW)
  ) u_scanner (
    .clk_i    (clkf),
    .rst_ni   (reset),
    .start_i  (w_start),
    .advance_i(w_advance),
    .rect_i   (job_q),
    .x_o      (pix_x),
    .y_o      (pix_y),
    .last_o   (w_last)
  );

  // Job sequencer; every output is registered on the transition into its state.
  always_ff @(posedge clkf or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      job_q   <= '0;
      grant_q <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      we_q    <= 1'b0;
    end else begin
      grant_q <= '0;
      done_q  <= '0;
      case (state_q)
        IDLE: begin
          if (pick_valid_d) begin
            job_q   <= pick_rect_d;
            idx_q   <= pick_idx_d;
            grant_q <= ONEHOT0 << pick_idx_d;
            busy_q  <= 1'b1;
            state_q <= LOAD;
          end
        end
        LOAD: begin
          if (degenerate(job_q)) begin
            done_q  <= ONEHOT0 << idx_q;
            state_q <= DONE;
          end else begin
            we_q    <= 1'b1;
            state_q <= SCAN;
          end
        end
        SCAN: begin
          if (w_ready && w_last) begin
            we_q    <= 1'b0;
            done_q  <= ONEHOT0 << idx_q;
            state_q <= DONE;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          ptr_q   <= ptr_d;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Colour storage is wider than COLW; only the low bits drive the output.
  assign w_unused_color = ^job_q.color;

  assign grant     = grant_q;
  assign done      = done_q;
  assign busy      = busy_q;
  assign pix_we    = we_q;
  assign pix_color = job_q.color[COLW-1:0];

endmodule
`default_nettype wire

// File: tb/tb_rect_draw_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_rect_draw_arbiter
// Purpose  : Directed self-checking bench for rect_draw_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rect_draw_arbiter;

  localparam int NREQ = 4;
  localparam int CW   = 11;
  localparam int COLW = 1;

  logic                 clkf;
  logic                 reset;
  logic [NREQ-1:0]      req;
  logic [NREQ*CW-1:0]   llx_v, lly_v, trx_v, try_v;
  logic [NREQ*COLW-1:0] col_v;
  logic                 pix_ready;
  logic [NREQ-1:0]      grant, done;
  logic                 busy;
  logic [CW-1:0]        pix_x, pix_y;
  logic [COLW-1:0]      pix_color;
  logic                 pix_we;

  int tests = 0;
  int fails = 0;

  rect_draw_arbiter #(.NREQ(NREQ), .CW(CW), .COLW(COLW)) dut (
    .clkf     (clkf),
    .reset    (reset),
    .req      (req),
    .llx      (llx_v),
    .lly      (lly_v),
    .trx      (trx_v),
    .try      (try_v),
    .color    (col_v),
`ifdef RECT_DRAW_STALL_EN
    .pix_ready(pix_ready),
`endif
    .grant    (grant),
    .done     (done),
    .busy     (busy),
    .pix_x    (pix_x),
    .pix_y    (pix_y),
    .pix_color(pix_color),
    .pix_we   (pix_we)
  );

  initial clkf = 1'b0;
  always #5 clkf = ~clkf;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clkf);
    #1;
  endtask

  task automatic set_rect(input int c, input int a, input int b, input int cx, input int d, input int col);
    llx_v[c*CW +: CW]     = CW'(a);
    lly_v[c*CW +: CW]     = CW'(b);
    trx_v[c*CW +: CW]     = CW'(cx);
    try_v[c*CW +: CW]     = CW'(d);
    col_v[c*COLW +: COLW] = COLW'(col);
  endtask

  initial begin
    int accepted;
    reset = 1'b0; req = '0; pix_ready = 1'b1;
    llx_v = '0; lly_v = '0; trx_v = '0; try_v = '0; col_v = '0;
    tick(); tick();
    check("reset_grant", grant, 0);
    check("reset_done", done, 0);
    check("reset_busy", busy, 0);
    check("reset_we", pix_we, 0);
    check("reset_x", pix_x, 0);
    reset = 1'b1;

    // Single job, client 1, 2x3 rectangle.
    set_rect(1, 2, 3, 3, 5, 1);
    req = 4'b0010;
    tick();
    check("t1_grant", grant, 4'b0010);
    check("t1_busy", busy, 1);
    check("t1_we_load", pix_we, 0);
    for (int xx = 2; xx <= 3; xx++) begin
      for (int yy = 3; yy <= 5; yy++) begin
        tick();
        check("t1_we", pix_we, 1);
        check("t1_x", pix_x, xx);
        check("t1_y", pix_y, yy);
        check("t1_col", pix_color, 1);
      end
    end
    tick();
    check("t1_done", done, 4'b0010);
    check("t1_we_done", pix_we, 0);
    check("t1_grant_done", grant, 0);
    req = '0;
    tick();
    check("t1_done_clr", done, 0);
    check("t1_idle_busy", busy, 0);

    // Contention from reset: all four clients with 1x1 rectangles.
    reset = 1'b0;
    for (int i = 0; i < NREQ; i++) set_rect(i, i, i, i, i, i & 1);
    req = 4'b1111;
    tick(); tick();
    reset = 1'b1;
    for (int g = 0; g < 5; g++) begin
      tick();
      check("t2_grant", grant, 1 << (g % 4));
      tick();
      check("t2_we", pix_we, 1);
      check("t2_x", pix_x, g % 4);
      check("t2_y", pix_y, g % 4);
      check("t2_col", pix_color, (g % 4) & 1);
      tick();
      check("t2_done", done, 1 << (g % 4));
      check("t2_nogrant", grant, 0);
      if (g == 4) req = '0;
      tick();
      check("t2_idle_grant", grant, 0);
      check("t2_idle_busy", busy, 0);
    end

    // Degenerate: trx < llx, pointer now at 1, client 2 requests.
    set_rect(2, 5, 0, 4, 0, 1);
    req = 4'b0100;
    tick();
    check("t3_grant", grant, 4'b0100);
    check("t3_we_load", pix_we, 0);
    tick();
    check("t3_done", done, 4'b0100);
    check("t3_we_done", pix_we, 0);
    req = '0;
    tick();
    check("t3_we_idle", pix_we, 0);
    check("t3_busy_idle", busy, 0);

    // Reset mid-scan; pointer is 3 so client 1 wins by wrapping.
    set_rect(1, 2, 3, 3, 5, 0);
    req = 4'b0010;
    tick();
    check("t5_grant", grant, 4'b0010);
    tick(); tick(); tick();
    check("t5_pix3_y", pix_y, 5);
    check("t5_pix3_we", pix_we, 1);
    reset = 1'b0;
    #1;
    check("t5_async_we", pix_we, 0);
    check("t5_async_busy", busy, 0);
    check("t5_async_x", pix_x, 0);
    check("t5_async_y", pix_y, 0);
    check("t5_async_done", done, 0);
    set_rect(3, 0, 2045, 0, 2047, 1);
    req = 4'b1010;
    tick();
    check("t5_held_done", done, 0);
    tick();
    reset = 1'b1;
    tick();
    check("t5_regrant_ptr0", grant, 4'b0010);
    for (int xx = 2; xx <= 3; xx++) begin
      for (int yy = 3; yy <= 5; yy++) begin
        tick();
        check("t5_x", pix_x, xx);
        check("t5_y", pix_y, yy);
      end
    end
    tick();
    check("t5_done", done, 4'b0010);
    req = 4'b1000;
    tick();
    check("t5_gap_grant", grant, 0);

    // Top-of-range y: 2045..2047 must terminate.
    tick();
    check("t4_grant", grant, 4'b1000);
    for (int yy = 2045; yy <= 2047; yy++) begin
      tick();
      check("t4_we", pix_we, 1);
      check("t4_x", pix_x, 0);
      check("t4_y", pix_y, yy);
    end
    tick();
    check("t4_done", done, 4'b1000);
    check("t4_we_done", pix_we, 0);
    req = '0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t4_we_after", pix_we, 0);
      check("t4_done_after", done, 0);
    end

`ifdef RECT_DRAW_STALL_EN
    // Stall: pixel 1 held three extra cycles.
    accepted = 0;
    set_rect(0, 10, 7, 11, 7, 1);
    req = 4'b0001;
    tick();
    check("t6_grant", grant, 4'b0001);
    pix_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t6_stall_we", pix_we, 1);
      check("t6_stall_x", pix_x, 10);
      check("t6_stall_done", done, 0);
      if (pix_we && pix_ready) accepted++;
    end
    pix_ready = 1'b1;
    tick();
    check("t6_p1_x", pix_x, 10);
    if (pix_we && pix_ready) accepted++;
    tick();
    check("t6_p2_x", pix_x, 11);
    check("t6_p2_y", pix_y, 7);
    if (pix_we && pix_ready) accepted++;
    tick();
    check("t6_done", done, 4'b0001);
    check("t6_accepted", accepted, 2);
    req = '0;
    tick();
`else
    accepted = 0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
